// File: rtl/bht_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bht_pkg: counter encodings, FSM states and update-entry type. Rev 1.0
// ----------------------------------------------------------------------------
package bht_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Index width carried by a queued update; the controller's IDX_W must match.
  localparam int unsigned UPD_IDX_W = 5;

  typedef struct packed {
    logic [UPD_IDX_W-1:0] idx;
    logic                 taken;
  } upd_entry_t;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    end
    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bht_upd_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bht_upd_fifo: synchronous FIFO holding resolved-branch updates. Rev 1.0
// ----------------------------------------------------------------------------
module bht_upd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/bht_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bht_controller: 2-bit branch history table shared by lookup and update. Rev 1.0
// ----------------------------------------------------------------------------
module bht_controller
  import bht_pkg::*;
#(
  parameter int IDX_W     = 5,
  parameter int UPD_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             lkp_valid,
  output logic             lkp_ready,
  input  logic [IDX_W-1:0] lkp_index,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  output logic             init_done
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             init_done_q, init_done_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [1:0]       table_q [ENTRIES];
  logic [1:0]       table_d [ENTRIES];

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop, lkp_fire;
  logic [IDX_W:0]   fifo_head;
  upd_entry_t       head_e;

  assign lkp_ready = init_done_q & ~fifo_full;
  assign upd_ready = init_done_q & ~fifo_full;
  assign lkp_fire  = lkp_valid & lkp_ready;
  assign fifo_push = upd_valid & upd_ready;
  // A full FIFO blocks lookups, so the head is guaranteed the table that cycle.
  assign fifo_pop  = (state_q == ST_RUN) & ~fifo_empty & ~lkp_fire;
  assign head_e    = upd_entry_t'(fifo_head);

  bht_upd_fifo #(
    .DEPTH  (UPD_DEPTH),
    .DATA_W (IDX_W + 1)
  ) u_upd_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({upd_index, upd_taken}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    init_done_d  = init_done_q;
    pred_valid_d = lkp_fire;
    pred_taken_d = pred_taken_q;
    table_d      = table_q;
    if (lkp_fire) begin
      pred_taken_d = table_q[lkp_index][1];
    end
    case (state_q)
      ST_INIT: begin
        table_d[ptr_q] = CNT_WNT;
        ptr_d          = ptr_q + IDX_W'(1);
        if (&ptr_q) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      default: begin
        if (fifo_pop) begin
          table_d[head_e.idx] = cnt_next(table_q[head_e.idx], head_e.taken);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      init_done_q  <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      init_done_q  <= init_done_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  // The table itself needs no reset: INIT rewrites every entry.
  always_ff @(posedge clock) begin
    table_q <= table_d;
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign init_done  = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bht_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bht_controller: directed vectors for bht_controller. Rev 1.0
// ----------------------------------------------------------------------------
module tb_bht_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       lkp_valid = 1'b0;
  logic       lkp_ready;
  logic [4:0] lkp_index = '0;
  logic       pred_valid, pred_taken;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic [4:0] upd_index = '0;
  logic       upd_taken = 1'b0;
  logic       init_done;

  int n_vec = 0;
  int n_err = 0;

  bht_controller #(.IDX_W(5), .UPD_DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .lkp_valid  (lkp_valid),
    .lkp_ready  (lkp_ready),
    .lkp_index  (lkp_index),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_index  (upd_index),
    .upd_taken  (upd_taken),
    .init_done  (init_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    bit early = 1'b0;
    while (!init_done && n < 100) begin
      step();
      n++;
      if (!init_done && (lkp_ready || upd_ready)) early = 1'b1;
    end
    chk({tag, "_cycles"}, 32'(n), 32);
    chk({tag, "_rdy_early"}, 32'(early), 0);
    chk({tag, "_rdy_after"}, 32'({lkp_ready, upd_ready}), 3);
  endtask

  task automatic lookup(input logic [4:0] idx, input logic exp, input string tag);
    lkp_valid = 1'b1;
    lkp_index = idx;
    for (int k = 0; k < 20 && !lkp_ready; k++) step();
    step();
    lkp_valid = 1'b0;
    chk(tag, 32'({pred_valid, pred_taken}), 32'({1'b1, exp}));
  endtask

  task automatic push(input logic [4:0] idx, input logic t);
    upd_valid = 1'b1;
    upd_index = idx;
    upd_taken = t;
    for (int k = 0; k < 20 && !upd_ready; k++) step();
    chk("push_rdy", 32'(upd_ready), 1);
    step();
    upd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values, then INIT length
    step();
    step();
    chk("rst_outputs", 32'({pred_valid, pred_taken, init_done, lkp_ready, upd_ready}), 0);
    reset = 1'b0;
    wait_init("t1_init");

    // Fresh table predicts weak not-taken
    lookup(5'd7, 1'b0, "t2_idx7");
    step();
    chk("t2_pulse", 32'(pred_valid), 0);
    lookup(5'd0, 1'b0, "t2_idx0");
    lookup(5'd31, 1'b0, "t2_idx31");

    // Saturating counter on idx 3
    idle(2);
    push(5'd3, 1'b1);
    push(5'd3, 1'b1);
    idle(6);
    lookup(5'd3, 1'b1, "t3_two_taken");
    for (int i = 0; i < 5; i++) push(5'd3, 1'b1);
    idle(8);
    lookup(5'd3, 1'b1, "t3_sat_high");
    push(5'd3, 1'b0);
    idle(4);
    lookup(5'd3, 1'b1, "t3_one_nt");
    for (int i = 0; i < 3; i++) push(5'd3, 1'b0);
    idle(6);
    lookup(5'd3, 1'b0, "t3_sat_low");
    push(5'd3, 1'b1);
    idle(4);
    lookup(5'd3, 1'b0, "t3_no_wrap");

    // Lookups every cycle starve the FIFO until it fills
    idle(4);
    lkp_valid = 1'b1;
    lkp_index = 5'd10;
    upd_valid = 1'b1;
    upd_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      upd_index = 5'(20 + i);
      step();
    end
    upd_valid = 1'b0;
    chk("t4_full_lkp_rdy", 32'(lkp_ready), 0);
    chk("t4_full_upd_rdy", 32'(upd_ready), 0);
    chk("t4_pred_before", 32'(pred_valid), 1);
    step();
    chk("t4_drain_cycle", 32'({pred_valid, lkp_ready}), 32'(2'b01));
    step();
    chk("t4_resume", 32'({pred_valid, pred_taken}), 32'(2'b10));
    step();
    lkp_valid = 1'b0;
    idle(8);
    for (int i = 0; i < 4; i++) lookup(5'(20 + i), 1'b1, "t4_no_loss");

    // Push+pop at count 2, then order NT,NT,NT,T,T on idx 12 -> counter 10
    idle(4);
    lkp_valid = 1'b1;
    lkp_index = 5'd0;
    upd_valid = 1'b1;
    upd_index = 5'd12;
    upd_taken = 1'b0;
    step();
    step();
    lkp_valid = 1'b0;
    chk("t5_rdy_at2", 32'(upd_ready), 1);
    step();
    lkp_valid = 1'b1;
    upd_taken = 1'b1;
    step();
    chk("t5_rdy_at3", 32'(upd_ready), 1);
    step();
    chk("t5_full_at4", 32'(upd_ready), 0);
    upd_valid = 1'b0;
    lkp_valid = 1'b0;
    idle(8);
    lookup(5'd12, 1'b1, "t5_order");

    // Reset with updates pending and a prediction in flight
    idle(4);
    lkp_valid = 1'b1;
    lkp_index = 5'd12;
    upd_valid = 1'b1;
    upd_index = 5'd5;
    upd_taken = 1'b1;
    step();
    step();
    step();
    lkp_valid = 1'b0;
    upd_valid = 1'b0;
    chk("t6_inflight", 32'({pred_valid, pred_taken}), 32'(2'b11));
    reset = 1'b1;
    step();
    chk("t6_killed", 32'({pred_valid, pred_taken, init_done, lkp_ready, upd_ready}), 0);
    step();
    reset = 1'b0;
    wait_init("t6_init");
    idle(6);
    for (int i = 0; i < 32; i++) lookup(5'(i), 1'b0, "t6_clear");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
